// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational ALU: registers an operation onto the ALU inputs and waits a per-opcode settle time.
// It then captures the ALU result and flags into a held response. Define ALU_OPCHECK_EN to reject opcodes above 5 with rsp_err.
module alu_cmd_issuer #(
    parameter int WIDTH    = 128,
    parameter int SHIFT_W  = 5,
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SHIFT_W-1:0] cmd_shamt,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHIFT_W-1:0] alu_shift,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_ovf,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_ovf,
    output logic               rsp_err
);

    localparam int MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd5;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0]   alu_input1_q, alu_input1_d;
    logic [WIDTH-1:0]   alu_input2_q, alu_input2_d;
    logic [SHIFT_W-1:0] alu_shift_q, alu_shift_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic               rsp_err_q, rsp_err_d;
    logic               cmd_illegal;
    logic               flags_kept;

`ifdef ALU_OPCHECK_EN
    assign cmd_illegal = (cmd_opcode > OP_MUL);
`else
    assign cmd_illegal = 1'b0;
`endif

    assign cmd_ready  = (state_q == S_IDLE);
    // Only ADD and SUB produce meaningful carry/overflow; anything else reports them clear.
    assign flags_kept = (alu_opcode_q <= OP_SUB);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_input1_d = alu_input1_q;
        alu_input2_d = alu_input2_q;
        alu_shift_d  = alu_shift_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal) begin
                        // Rejected opcode never reaches the ALU; answer immediately.
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_zero_d   = 1'b1;
                        rsp_ovf_d    = 1'b0;
                        rsp_err_d    = 1'b1;
                    end else begin
                        state_d      = S_WAIT;
                        alu_opcode_d = cmd_opcode;
                        alu_input1_d = cmd_a;
                        alu_input2_d = cmd_b;
                        alu_shift_d  = cmd_shamt;
                        cnt_d        = (cmd_opcode == OP_MUL) ? CNT_W'(MUL_LAT - 1)
                                                              : CNT_W'(BASE_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_carry_d  = flags_kept & alu_carry;
                    rsp_ovf_d    = flags_kept & alu_ovf;
                    rsp_zero_d   = (alu_result == '0);
                    rsp_err_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_opcode_q <= '0;
            alu_input1_q <= '0;
            alu_input2_q <= '0;
            alu_shift_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_input1_q <= alu_input1_d;
            alu_input2_q <= alu_input2_d;
            alu_shift_q  <= alu_shift_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_input1 = alu_input1_q;
    assign alu_input2 = alu_input2_q;
    assign alu_shift  = alu_shift_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: table of operations with expected responses, scoreboard queue, plus reset corner sequences.
module tb_alu_cmd_issuer;

    localparam int W  = 128;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = '0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic [SW-1:0] cmd_shamt = '0;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_input1;
    logic [W-1:0]  alu_input2;
    logic [SW-1:0] alu_shift;
    logic [W-1:0]  alu_result;
    logic          alu_carry;
    logic          alu_ovf;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry;
    logic          rsp_zero;
    logic          rsp_ovf;
    logic          rsp_err;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(W), .SHIFT_W(SW), .BASE_LAT(1), .MUL_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    // Combinational ALU stand-in; it deliberately drives garbage flags for AND/OR/SLL/MUL.
    logic [W:0] sum_ext;
    always_comb begin
        sum_ext    = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_opcode)
            4'd0: begin
                sum_ext    = {1'b0, alu_input1} + {1'b0, alu_input2};
                alu_result = sum_ext[W-1:0];
                alu_carry  = sum_ext[W];
                alu_ovf    = (alu_input1[W-1] == alu_input2[W-1]) && (alu_result[W-1] != alu_input1[W-1]);
            end
            4'd1: begin
                sum_ext    = {1'b0, alu_input1} + {1'b0, ~alu_input2} + {{W{1'b0}}, 1'b1};
                alu_result = sum_ext[W-1:0];
                alu_carry  = sum_ext[W];
                alu_ovf    = (alu_input1[W-1] != alu_input2[W-1]) && (alu_result[W-1] != alu_input1[W-1]);
            end
            4'd2: begin alu_result = alu_input1 & alu_input2; alu_carry = 1'b1; alu_ovf = 1'b1; end
            4'd3: begin alu_result = alu_input1 | alu_input2; alu_carry = 1'b1; alu_ovf = 1'b1; end
            4'd4: begin alu_result = alu_input1 << alu_shift; alu_carry = 1'b1; alu_ovf = 1'b1; end
            4'd5: begin alu_result = alu_input1 * alu_input2; alu_carry = 1'b1; alu_ovf = 1'b1; end
            default: alu_result = alu_input1 ^ alu_input2;
        endcase
    end

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [SW-1:0] sh;
        int            hold;
        int            lat;
        logic [W-1:0]  res;
        logic          carry;
        logic          zero;
        logic          ovf;
        logic          err;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         ovf;
        logic         err;
    } exp_t;

    localparam int NV = 8;
    vec_t vecs [NV];
    exp_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    logic [3:0]   last_op = '0;
    logic [W-1:0] last_a  = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One full transaction: accept, bounded wait for response, optional backpressure, handshake.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sh, input int hold, input int lat);
        int   n;
        logic illegal;
        exp_t e;
`ifdef ALU_OPCHECK_EN
        illegal = (op > 4'd5);
`else
        illegal = 1'b0;
`endif
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_valid = 1'b1;
        chk("cmd_ready_idle", W'(cmd_ready), W'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!illegal) begin
            last_op = op;
            last_a  = a;
        end
        chk("alu_opcode", W'(alu_opcode), W'(last_op));
        chk("alu_input1", alu_input1, last_a);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency", W'(n), W'(lat));
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", W'(0), W'(1));
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            cmd_opcode = 4'd3; cmd_a = ~a; cmd_valid = 1'b1;
            chk("hold_valid", W'(rsp_valid), W'(1));
            chk("hold_result", rsp_result, e.res);
            chk("hold_cmd_ready", W'(cmd_ready), W'(0));
            chk("hold_alu_input1", alu_input1, last_a);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_carry", W'(rsp_carry), W'(e.carry));
        chk("rsp_zero", W'(rsp_zero), W'(e.zero));
        chk("rsp_ovf", W'(rsp_ovf), W'(e.ovf));
        chk("rsp_err", W'(rsp_err), W'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_hs_valid", W'(rsp_valid), W'(0));
        chk("post_hs_ready", W'(cmd_ready), W'(1));
        chk("post_hs_result_kept", rsp_result, e.res);
        $display("op %0d a=%0h b=%0h sh=%0d -> result %0h c%0b z%0b o%0b e%0b latency %0d",
                 op, a, b, sh, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err, n);
    endtask

    initial begin
        logic seen;
        logic [W-1:0] ones;
        logic [W-1:0] msb;
        ones = {W{1'b1}};
        msb  = {1'b1, {(W-1){1'b0}}};

        //          op     a              b       sh  hold lat res               c     z     o     e
        vecs[0] = '{4'd0, ones,          W'(1),  0,  0,   1,  '0,               1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'd5, W'(6),         W'(7),  0,  0,   3,  W'(42),           1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'd1, W'(7),         W'(5),  0,  0,   1,  W'(2),            1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd1, msb,           W'(1),  0,  0,   1,  ~msb,             1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'd0, ~msb,          W'(1),  0,  2,   1,  msb,              1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'd2, W'(8'hF0),     W'(8'h3C), 0, 0, 1,  W'(8'h30),        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'd4, W'(1),         W'(0),  4,  5,   1,  W'(8'h10),        1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ALU_OPCHECK_EN
        vecs[7] = '{4'd9, W'(3),         W'(5),  0,  0,   0,  '0,               1'b0, 1'b1, 1'b0, 1'b1};
`else
        vecs[7] = '{4'd9, W'(3),         W'(5),  0,  0,   1,  W'(6),            1'b0, 1'b0, 1'b0, 1'b0};
`endif

        #12;
        chk("reset_rsp_valid", W'(rsp_valid), W'(0));
        chk("reset_cmd_ready", W'(cmd_ready), W'(1));
        chk("reset_alu_input1", alu_input1, '0);
        chk("reset_rsp_result", rsp_result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            exp_q.push_back('{vecs[i].res, vecs[i].carry, vecs[i].zero, vecs[i].ovf, vecs[i].err});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].hold, vecs[i].lat);
        end

        // Asynchronous reset mid-simulation takes effect without a clock edge.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", W'(rsp_valid), W'(0));
        chk("async_rst_ready", W'(cmd_ready), W'(1));
        chk("async_rst_alu_input1", alu_input1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        last_op = '0;
        last_a  = '0;
        @(posedge clk); #1;

        // Reset while a MUL is settling: that operation must never respond.
        cmd_opcode = 4'd5; cmd_a = W'(6); cmd_b = W'(7); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_reset", W'(seen), W'(0));
        $display("mul aborted by reset, rsp_valid seen=%0b", seen);

        exp_q.push_back('{W'(7), 1'b0, 1'b0, 1'b0, 1'b0});
        run_op(4'd0, W'(3), W'(4), 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
